// File: rtl/bl_serial_alu_pkg.sv
// rtl/bl_serial_alu_pkg.sv - shared types and op decoding for the bit-serial bit-line ALU
package bl_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_RESERVED     = 2'd3;
    localparam op_e        OP_RESERVED_MAP = OP_ADD;

    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:        return OP_SUB;
            2'd2:        return OP_CMP;
            OP_RESERVED: return OP_RESERVED_MAP;
            default:     return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bl_serial_alu_if.sv
// rtl/bl_serial_alu_if.sv - controller/array bus of the serial ALU; BL_LANE_MASK_EN adds lane masking
interface bl_serial_alu_if #(
    parameter int LANES   = 8,
    parameter int OP_BITS = 8
);
    localparam int IDX_W = (OP_BITS > 1) ? $clog2(OP_BITS) : 1;

    logic              start;
    logic [1:0]        op;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic              rd_inv_b;
    logic [IDX_W-1:0]  bit_idx;
    logic [LANES-1:0]  bl;
    logic [LANES-1:0]  blb;
    logic              bl_valid;
    logic              wr_en;
    logic [LANES-1:0]  wr_data;
    logic [LANES-1:0]  cout;
`ifdef BL_LANE_MASK_EN
    logic [LANES-1:0]  lane_mask;
    logic [LANES-1:0]  wr_lane_en;

    modport master (
        output start, op, bl, blb, bl_valid, lane_mask,
        input  busy, done, rd_en, rd_inv_b, bit_idx, wr_en, wr_data, cout, wr_lane_en
    );
    modport slave (
        input  start, op, bl, blb, bl_valid, lane_mask,
        output busy, done, rd_en, rd_inv_b, bit_idx, wr_en, wr_data, cout, wr_lane_en
    );
`else
    modport master (
        output start, op, bl, blb, bl_valid,
        input  busy, done, rd_en, rd_inv_b, bit_idx, wr_en, wr_data, cout
    );
    modport slave (
        input  start, op, bl, blb, bl_valid,
        output busy, done, rd_en, rd_inv_b, bit_idx, wr_en, wr_data, cout
    );
`endif

endinterface

// File: rtl/bl_serial_alu_lane_cell.sv
// rtl/bl_serial_alu_lane_cell.sv - one lane: ripple sum/carry from sensed BL/BLB with a carry flop
module bl_lane_cell (
    input  logic clk,
    input  logic rst,
    input  logic init_i,
    input  logic init_val_i,
    input  logic en_i,
    input  logic bl_i,
    input  logic blb_i,
    output logic sum_o,
    output logic carry_d_o
);
    logic carry_q;
    logic carry_d;
    logic prop;

    // BL=A&B and BLB=~(A|B) are both low exactly when A^B, i.e. the propagate term.
    always_comb begin
        prop    = ~(bl_i | blb_i);
        sum_o   = prop ^ carry_q;
        carry_d = carry_q;
        if (init_i) begin
            carry_d = init_val_i;
        end else if (en_i) begin
            carry_d = bl_i | (prop & carry_q);
        end
    end

    assign carry_d_o = carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/bl_serial_alu.sv
// rtl/bl_serial_alu.sv - bit-serial in-array ADD/SUB/CMP sequencer; BL_LANE_MASK_EN enables per-lane write masking
module bl_serial_alu
    import bl_alu_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int OP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bl_serial_alu_if.slave       bus
);
    localparam int               IDX_W    = (OP_BITS > 1) ? $clog2(OP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OP_BITS - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [LANES-1:0]   wr_data_q, wr_data_d;
    logic [LANES-1:0]   cout_q, cout_d;
    logic               rd_inv_b_q, rd_inv_b_d;

    logic               accept;
    logic               step;
    logic               last_bit;
    op_e                start_op;
    logic [LANES-1:0]   mask_q;
    logic [LANES-1:0]   lane_en;
    logic [LANES-1:0]   sum;
    logic [LANES-1:0]   carry_nxt;

    assign accept   = (state_q == IDLE) && bus.start;
    assign step     = (state_q == READ) && bus.bl_valid;
    assign last_bit = (bit_idx_q == LAST_IDX);
    assign start_op = decode_op(bus.op);
    assign lane_en  = step ? mask_q : '0;

`ifdef BL_LANE_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= bus.lane_mask;
        end
    end

    assign bus.wr_lane_en = mask_q;
`else
    assign mask_q = '1;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bl_lane_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .init_i     (accept),
            .init_val_i (start_op != OP_ADD),
            .en_i       (lane_en[g]),
            .bl_i       (bus.bl[g]),
            .blb_i      (bus.blb[g]),
            .sum_o      (sum[g]),
            .carry_d_o  (carry_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = READ;
            READ: begin
                if (bus.bl_valid) begin
                    if (op_q != OP_CMP) begin
                        state_d = WRITE;
                    end else if (last_bit) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: state_d = last_bit ? DONE : READ;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        bit_idx_d  = bit_idx_q;
        wr_data_d  = wr_data_q;
        cout_d     = cout_q;
        rd_inv_b_d = rd_inv_b_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d       = start_op;
                    bit_idx_d  = '0;
                    rd_inv_b_d = (start_op != OP_ADD);
                end
            end
            READ: begin
                if (bus.bl_valid) begin
                    wr_data_d = sum;
                    if (op_q == OP_CMP && !last_bit) begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                if (!last_bit) begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            DONE:    rd_inv_b_d = 1'b0;
            default: ;
        endcase
        // Capture on entry so cout is already valid in the cycle done pulses.
        if (state_d == DONE && state_q != DONE) begin
            cout_d = carry_nxt & mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ADD;
            bit_idx_q  <= '0;
            wr_data_q  <= '0;
            cout_q     <= '0;
            rd_inv_b_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            bit_idx_q  <= bit_idx_d;
            wr_data_q  <= wr_data_d;
            cout_q     <= cout_d;
            rd_inv_b_q <= rd_inv_b_d;
        end
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.rd_en    = (state_q == READ);
        bus.wr_en    = (state_q == WRITE);
        bus.rd_inv_b = rd_inv_b_q;
        bus.bit_idx  = bit_idx_q;
        bus.wr_data  = wr_data_q;
        bus.cout     = cout_q;
    end

endmodule

// File: tb/tb_bl_serial_alu.sv
// tb/tb_bl_serial_alu.sv - directed self-checking bench for bl_serial_alu with a bit-line array model
module tb_bl_serial_alu;
    localparam int LANES   = 4;
    localparam int OP_BITS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bl_serial_alu_if #(.LANES(LANES), .OP_BITS(OP_BITS)) bus ();
    bl_serial_alu #(.LANES(LANES), .OP_BITS(OP_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  a_row [LANES];
    logic [3:0]  b_row [LANES];
    logic [3:0]  res   [LANES];
    int          valid_mode = 0;
    int          vcnt = 0;
    int          lat, nwr, gaps;
    logic        inv1;

`ifdef BL_LANE_MASK_EN
    initial bus.lane_mask = '1;
`endif

    // Array model: sense row pair bit_idx, complementing B when asked.
    always_comb begin
        bus.bl  = '0;
        bus.blb = '0;
        for (int l = 0; l < LANES; l++) begin
            logic av, bv;
            av = a_row[l][bus.bit_idx];
            bv = b_row[l][bus.bit_idx] ^ bus.rd_inv_b;
            bus.bl[l]  = av & bv;
            bus.blb[l] = ~(av | bv);
        end
    end

    // Mode 0: bl_valid always high; mode 1: three wait cycles per READ.
    always @(negedge clk) begin
        if (valid_mode == 0) begin
            bus.bl_valid = 1'b1;
        end else if (!bus.rd_en) begin
            vcnt = 0;
            bus.bl_valid = 1'b0;
        end else if (bus.bl_valid) begin
            vcnt = 1;
            bus.bl_valid = 1'b0;
        end else if (vcnt >= 3) begin
            bus.bl_valid = 1'b1;
        end else begin
            vcnt++;
        end
    end

    task automatic set_rows(input logic [15:0] a, input logic [15:0] b);
        for (int l = 0; l < LANES; l++) begin
            a_row[l] = a[l*4 +: 4];
            b_row[l] = b[l*4 +: 4];
        end
    endtask

    task automatic run_op(input logic [1:0] o, input bit poke, output int l_o, output int w_o,
                          output int g_o, output logic inv_o);
        for (int l = 0; l < LANES; l++) res[l] = 4'h0;
        @(negedge clk);
        bus.op    = o;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        l_o = 0; w_o = 0; g_o = 0;
        inv_o = bus.rd_inv_b;
        for (int c = 1; c <= 100; c++) begin
            if (poke && c == 3) begin
                bus.start = 1'b1;
                bus.op    = 2'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.wr_en) begin
                w_o++;
                for (int l = 0; l < LANES; l++) res[l][bus.bit_idx] = bus.wr_data[l];
            end
            if (bus.done) begin
                l_o = c;
                break;
            end
            if (!bus.rd_en && !bus.wr_en) g_o++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (l_o == 0) begin
            checks++; errors++;
            $display("FAIL op_timeout op=%0d no done within 100 cycles", o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        set_rows(16'h0, 16'h0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.rd_inv_b, bus.wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {bus.busy, bus.done, bus.rd_en, bus.rd_inv_b, bus.wr_en});
        end
        checks++;
        if (bus.bit_idx !== 2'd0) begin errors++; $display("FAIL reset_bit_idx got %0d want 0", bus.bit_idx); end
        checks++;
        if (bus.wr_data !== 4'b0) begin errors++; $display("FAIL reset_wr_data got %b want 0000", bus.wr_data); end
        checks++;
        if (bus.cout !== 4'b0) begin errors++; $display("FAIL reset_cout got %b want 0000", bus.cout); end
        rst = 1'b0;
    endtask

    task automatic test_add_uniform();
        set_rows(16'h5555, 16'h3333);
        run_op(2'd0, 1'b0, lat, nwr, gaps, inv1);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL add_latency got %0d want 9", lat); end
        checks++;
        if (nwr !== 4) begin errors++; $display("FAIL add_wr_count got %0d want 4", nwr); end
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'h8888) begin
            errors++; $display("FAIL add_result got %h want 8888", {res[3], res[2], res[1], res[0]});
        end
        checks++;
        if (bus.cout !== 4'b0000) begin errors++; $display("FAIL add_cout got %b want 0000", bus.cout); end
        checks++;
        if (inv1 !== 1'b0) begin errors++; $display("FAIL add_rd_inv_b got %b want 0", inv1); end
    endtask

    task automatic test_add_mixed(input logic [1:0] o, input string tag);
        set_rows(16'h6_0_7_F, 16'h6_0_9_1);
        run_op(o, 1'b0, lat, nwr, gaps, inv1);
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'hC000) begin
            errors++; $display("FAIL %s_result got %h want c000", tag, {res[3], res[2], res[1], res[0]});
        end
        checks++;
        if (bus.cout !== 4'b0011) begin errors++; $display("FAIL %s_cout got %b want 0011", tag, bus.cout); end
        checks++;
        if (inv1 !== 1'b0) begin errors++; $display("FAIL %s_rd_inv_b got %b want 0", tag, inv1); end
    endtask

    task automatic test_sub();
        set_rows(16'h0_0_5_3, 16'h0_0_3_5);
        run_op(2'd1, 1'b0, lat, nwr, gaps, inv1);
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'h002E) begin
            errors++; $display("FAIL sub_result got %h want 002e", {res[3], res[2], res[1], res[0]});
        end
        checks++;
        if (bus.cout !== 4'b1110) begin errors++; $display("FAIL sub_cout got %b want 1110", bus.cout); end
        checks++;
        if (inv1 !== 1'b1) begin errors++; $display("FAIL sub_rd_inv_b got %b want 1", inv1); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL sub_latency got %0d want 9", lat); end
    endtask

    task automatic test_cmp();
        set_rows(16'h0_9_2_4, 16'h1_2_9_4);
        run_op(2'd2, 1'b0, lat, nwr, gaps, inv1);
        checks++;
        if (nwr !== 0) begin errors++; $display("FAIL cmp_wr_count got %0d want 0", nwr); end
        checks++;
        if (bus.cout !== 4'b0101) begin errors++; $display("FAIL cmp_cout got %b want 0101", bus.cout); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL cmp_latency got %0d want 5", lat); end
        checks++;
        if (inv1 !== 1'b1) begin errors++; $display("FAIL cmp_rd_inv_b got %b want 1", inv1); end
    endtask

    task automatic test_delayed_valid();
        valid_mode = 1;
        set_rows(16'h6_0_7_F, 16'h6_0_9_1);
        run_op(2'd0, 1'b0, lat, nwr, gaps, inv1);
        valid_mode = 0;
        checks++;
        if (lat !== 21) begin errors++; $display("FAIL delay_latency got %0d want 21", lat); end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL delay_rd_en_dropped got %0d idle cycles want 0", gaps); end
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'hC000) begin
            errors++; $display("FAIL delay_result got %h want c000", {res[3], res[2], res[1], res[0]});
        end
        checks++;
        if (bus.cout !== 4'b0011) begin errors++; $display("FAIL delay_cout got %b want 0011", bus.cout); end
    endtask

    task automatic test_busy_start();
        int busy_cnt;
        set_rows(16'h5555, 16'h3333);
        run_op(2'd0, 1'b1, lat, nwr, gaps, inv1);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL busy_start_latency got %0d want 9", lat); end
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'h8888) begin
            errors++; $display("FAIL busy_start_result got %h want 8888", {res[3], res[2], res[1], res[0]});
        end
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0) begin errors++; $display("FAIL busy_start_queued got %0d busy cycles want 0", busy_cnt); end
    endtask

    task automatic test_rst_mid_write();
        bit hit;
        int wr_cnt;
        set_rows(16'h6_0_7_F, 16'h6_0_9_1);
        @(negedge clk);
        bus.op = 2'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (bus.wr_en && bus.bit_idx == 2'd1) begin
                hit = 1'b1;
                rst = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_write_bit1_seen got 0 want 1"); end
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.rd_inv_b, bus.wr_en, bus.bit_idx, bus.wr_data, bus.cout} !== 15'b0) begin
            errors++;
            $display("FAIL rst_outputs got %b want 0",
                     {bus.busy, bus.done, bus.rd_en, bus.rd_inv_b, bus.wr_en, bus.bit_idx, bus.wr_data, bus.cout});
        end
        rst = 1'b0;
        wr_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wr_en || bus.busy) wr_cnt++;
        end
        checks++;
        if (wr_cnt !== 0) begin errors++; $display("FAIL rst_activity_after got %0d want 0", wr_cnt); end
    endtask

    task automatic test_add_after_rst();
        set_rows(16'h8_A_1_9, 16'h8_A_2_4);
        run_op(2'd0, 1'b0, lat, nwr, gaps, inv1);
        checks++;
        if ({res[3], res[2], res[1], res[0]} !== 16'h043D) begin
            errors++; $display("FAIL post_rst_result got %h want 043d", {res[3], res[2], res[1], res[0]});
        end
        checks++;
        if (bus.cout !== 4'b1100) begin errors++; $display("FAIL post_rst_cout got %b want 1100", bus.cout); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL post_rst_latency got %0d want 9", lat); end
    endtask

    initial begin
        test_reset();
        test_add_uniform();
        test_add_mixed(2'd0, "add_mixed");
        test_add_mixed(2'd3, "reserved_op");
        test_sub();
        test_cmp();
        test_delayed_valid();
        test_busy_start();
        test_rst_mid_write();
        test_add_after_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bl_serial_alu.md
Name: bl_serial_alu

Overview:
- Bit-serial in-array arithmetic engine for the compute cache.
- Operates on LANES bit-line columns in parallel, one operand bit per step, LSB first.
- Each step it consumes sensed BL (A&B) and BLB (~(A|B)) per lane, keeps a per-lane carry latch, and writes the result bit back to the array.
- A start/done handshake with the array controller sequences the bit positions.

Parameters:
- LANES, 8, number of bit-line columns processed in parallel.
- OP_BITS, 8, operand width in bits; it sets the number of serial steps.
- IDX_W, $clog2(OP_BITS), width of the bit index (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- op  in  2  operation select: 0=ADD, 1=SUB, 2=CMP; 3 is reserved and treated as ADD.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  request the array to sense row pair bit_idx.
- rd_inv_b  out  1  tells the array to sense B complemented (SUB and CMP).
- bit_idx  out  IDX_W  current bit position, 0 upward.
- bl  in  LANES  sensed A&B per lane.
- blb  in  LANES  sensed ~(A|B) per lane.
- bl_valid  in  1  bl/blb are valid this cycle.
- wr_en  out  1  write the result row at bit_idx.
- wr_data  out  LANES  result bit per lane.
- cout  out  LANES  final carry per lane; for SUB/CMP this is the no-borrow flag (1 means A>=B).

Behaviour:
- Clock and reset: clk and rst are the only clock and reset. rst is synchronous, active-high.
- Reset state: FSM goes to IDLE. busy, done, rd_en, rd_inv_b, wr_en = 0; bit_idx = 0; wr_data = 0; cout = 0; carry latches = 0.
- Per-lane datapath:
  - x = ~(bl|blb) (propagate)
  - sum = x ^ c
  - c_next = bl | (x & c)
  - This is the same gate equivalent as the existing ripple cell, with the carry held in a flop between steps.
- States:
  - IDLE: if start, latch op and go to READ. Carry is set to 0 for ADD and to all-ones for SUB/CMP. bit_idx = 0. rd_inv_b = (op!=ADD) and is held until DONE.
  - READ: rd_en = 1. Stay in READ while bl_valid = 0, with no limit on waiting. When bl_valid = 1 the same cycle: register sum into wr_data and update carry.
    - ADD/SUB: go to WRITE.
    - CMP: if last bit go to DONE, else increment bit_idx and stay in READ.
  - WRITE: wr_en = 1 for exactly one cycle with bit_idx unchanged. If bit_idx == OP_BITS-1 go to DONE, else increment bit_idx and go to READ.
  - DONE: done = 1 for one cycle; cout = carry latches; go to IDLE.
- bl_valid outside READ is ignored.
- Latency with bl_valid held high: ADD/SUB assert done 2*OP_BITS+1 cycles after the start cycle; CMP asserts done OP_BITS+1 cycles after.
- start while busy is ignored, with no queuing.
- cout holds its value until the next DONE or rst.
- bit_idx never exceeds OP_BITS-1; no wrap occurs inside an operation.
- rst in any state aborts the operation. No further wr_en is issued, and the state is the reset state on the next cycle.

Optional Feature:
- Macro: BL_LANE_MASK_EN.
- With it defined:
  - Adds input lane_mask[LANES], latched on the accepted start.
  - Adds output wr_lane_en[LANES] = latched mask, valid whenever wr_en = 1.
  - Masked lanes (mask = 0) keep their carry frozen and report cout = 0.
- Without it: no extra ports, and all lanes are always written.

Decomposition:
- Package bl_alu_pkg holds:
  - op_e enum (OP_ADD, OP_SUB, OP_CMP)
  - state_e enum (IDLE, READ, WRITE, DONE)
  - localparam for the reserved-op mapping.
- Sub-module bl_lane_cell: one lane's combinational sum/carry plus its carry flop, with enable and synchronous init. It is instantiated LANES times by generate.

Test Plan (LANES=4, OP_BITS=4; the bench array model derives bl/blb from the A and B rows and applies ~B when rd_inv_b=1):
- ADD with A=5,B=3 on all lanes and bl_valid always high:
  - wr_data rows are bit0=0, bit1=0, bit2=0, bit3=1, giving result 8.
  - cout = 0000.
  - done is asserted at cycle 9 after start.
- ADD with lane0 15+1, lane1 7+9, lane2 0+0, lane3 6+6:
  - Results are 0, 0, 0, 12.
  - cout = 0011, where bit n is lane n.
- SUB with lane0 3-5, lane1 5-3:
  - Results are 14 and 2.
  - cout lane0 = 0, lane1 = 1.
- CMP with A=4,B=4 and A=2,B=9:
  - wr_en is never asserted.
  - cout flags are 1 and 0.
  - done is asserted at cycle 5 after start.
- bl_valid delayed 3 cycles per bit:
  - rd_en stays high throughout.
  - Results are unchanged.
  - done latency grows by 12 cycles.
- Timing edge cases:
  - start pulsed while busy has no effect.
  - rst asserted during WRITE of bit 1 gives no further wr_en; next cycle all outputs are 0.
  - A fresh ADD then completes correctly.
